// File: rtl/miss_handler.sv
// miss_handler: per-cache miss sequencer sitting behind the replacement
// controller. Latches the victim way on a miss, reads the victim from the
// tag/data arrays, writes it back when valid and dirty, fetches the new
// line from the next memory level and writes it into the victim way.
//
// Optional build macro: MISS_HANDLER_STATS_EN
//   defined   -> saturating 32-bit miss_count / wb_count counters
//   undefined -> miss_count / wb_count tied to 0, no counter flops
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   miss_valid/miss_ready        miss handshake (ready only in IDLE)
//   miss_index/miss_tag          address of the missing access
//   selected_way                 one-hot victim, sampled on the miss handshake
//   array_rd_en/index/way        victim read strobe and held array address
//   victim_*                     array read data, valid the cycle after array_rd_en
//   mem_req_*                    writeback / fill request to next level
//   mem_rsp_valid/rdata          fill data return
//   fill_we/fill_tag/fill_line   array write of the fetched line
//   access_valid/current_access  access report to the replacement controller
//   miss_done                    completion pulse
//   miss_count/wb_count          statistics (see macro above)

package miss_handler_pkg;
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction
endpackage

module miss_handler #(
    parameter int  NUMBER_OF_WAYS = 8,
    parameter int  INDEX_BITS     = 8,
    parameter int  TAG_BITS       = 20,
    parameter int  LINE_WIDTH     = 128,
    localparam int WAY_BITS       = miss_handler_pkg::log2(NUMBER_OF_WAYS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [INDEX_BITS-1:0]        miss_index,
    input  logic [TAG_BITS-1:0]          miss_tag,
    input  logic [NUMBER_OF_WAYS-1:0]    selected_way,
    output logic                         array_rd_en,
    output logic [INDEX_BITS-1:0]        array_index,
    output logic [WAY_BITS-1:0]          array_way,
    input  logic                         victim_valid,
    input  logic                         victim_dirty,
    input  logic [TAG_BITS-1:0]          victim_tag,
    input  logic [LINE_WIDTH-1:0]        victim_line,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_write,
    output logic [TAG_BITS+INDEX_BITS-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0]        mem_req_wdata,
    input  logic                         mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0]        mem_rsp_rdata,
    output logic                         fill_we,
    output logic [TAG_BITS-1:0]          fill_tag,
    output logic [LINE_WIDTH-1:0]        fill_line,
    output logic                         access_valid,
    output logic [WAY_BITS-1:0]          current_access,
    output logic                         miss_done,
    output logic [31:0]                  miss_count,
    output logic [31:0]                  wb_count
);

    typedef enum logic [2:0] {
        IDLE, READ, EVAL, WB_REQ, FILL_REQ, FILL_WAIT, FILL
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   index_q;
    logic [TAG_BITS-1:0]     tag_q;
    logic [WAY_BITS-1:0]     way_q;
    logic [TAG_BITS-1:0]     vic_tag_q;
    logic [LINE_WIDTH-1:0]   vic_line_q;
    logic [LINE_WIDTH-1:0]   fill_line_q;
    logic [WAY_BITS-1:0]     way_enc;
    logic                    miss_accept;

    // Lowest set bit wins so a malformed multi-hot vector still picks a
    // single deterministic way; all-zero falls through to way 0.
    always_comb begin
        way_enc = '0;
        for (int i = NUMBER_OF_WAYS - 1; i >= 0; i--)
            if (selected_way[i]) way_enc = WAY_BITS'(i);
    end

    assign miss_accept = (state_q == IDLE) && miss_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            index_q     <= '0;
            tag_q       <= '0;
            way_q       <= '0;
            vic_tag_q   <= '0;
            vic_line_q  <= '0;
            fill_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_accept) begin
                index_q <= miss_index;
                tag_q   <= miss_tag;
                way_q   <= way_enc;
            end
            // Array data is only guaranteed during EVAL; capture it so the
            // writeback request can be held through backpressure.
            if (state_q == EVAL) begin
                vic_tag_q  <= victim_tag;
                vic_line_q <= victim_line;
            end
            if (state_q == FILL_WAIT && mem_rsp_valid)
                fill_line_q <= mem_rsp_rdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        miss_ready    = 1'b0;
        array_rd_en   = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        fill_we       = 1'b0;
        access_valid  = 1'b0;
        miss_done     = 1'b0;
        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_d = READ;
            end
            READ: begin
                array_rd_en = 1'b1;
                state_d     = EVAL;
            end
            EVAL: begin
                state_d = (victim_valid && victim_dirty) ? WB_REQ : FILL_REQ;
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {vic_tag_q, index_q};
                mem_req_wdata = vic_line_q;
                // Writes are posted: the handshake alone retires them.
                if (mem_req_ready) state_d = FILL_REQ;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_q, index_q};
                if (mem_req_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_rsp_valid) state_d = FILL;
            end
            FILL: begin
                fill_we      = 1'b1;
                access_valid = 1'b1;
                miss_done    = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign array_index    = index_q;
    assign array_way      = way_q;
    assign current_access = way_q;
    assign fill_tag       = tag_q;
    assign fill_line      = fill_line_q;

`ifdef MISS_HANDLER_STATS_EN
    logic [31:0] miss_cnt_q, wb_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (miss_accept && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if (state_q == WB_REQ && mem_req_ready && wb_cnt_q != '1)
                wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`else
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: doc/miss_handler.md
Name: miss_handler

Overview:
- Per-cache miss sequencer directly downstream of the replacement controller.
- On a miss it latches the victim way chosen by the replacement controller (one-hot `selected_way`), reads the victim's state from the tag/data arrays, and writes the victim back if it is valid and dirty.
- It then fetches the new line from the next memory level and writes it into the victim way.
- On fill it reports the access back to the replacement controller via `access_valid`/`current_access`.

Parameters:
- NUMBER_OF_WAYS, 8, associativity. Power of 2, ≥2.
- INDEX_BITS, 8, set index width.
- TAG_BITS, 20, tag width.
- LINE_WIDTH, 128, cache line width in bits.
- WAY_BITS = log2(NUMBER_OF_WAYS), derived with the codebase's local log2 function, not overridable.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- miss_valid  in  1  miss request
- miss_ready  out  1  high only in IDLE
- miss_index  in  INDEX_BITS  set of missing access
- miss_tag  in  TAG_BITS  tag of missing access
- selected_way  in  NUMBER_OF_WAYS  one-hot victim from replacement controller; sampled on miss handshake
- array_rd_en  out  1  one-cycle array read strobe
- array_index  out  INDEX_BITS  latched miss_index; held for the whole miss
- array_way  out  WAY_BITS  binary victim way; held for the whole miss
- victim_valid  in  1  victim line valid; array read data, valid the cycle after array_rd_en
- victim_dirty  in  1  victim line dirty; same timing as victim_valid
- victim_tag  in  TAG_BITS  victim tag; same timing
- victim_line  in  LINE_WIDTH  victim data; same timing
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = writeback, 0 = line fill read
- mem_req_addr  out  TAG_BITS+INDEX_BITS  {tag,index} line address
- mem_req_wdata  out  LINE_WIDTH  writeback data
- mem_rsp_valid  in  1  fill data valid
- mem_rsp_rdata  in  LINE_WIDTH  fill data
- fill_we  out  1  write fill_tag/fill_line into array_index/array_way; marks line valid and clean
- fill_tag  out  TAG_BITS  latched miss_tag
- fill_line  out  LINE_WIDTH  registered fill data
- access_valid  out  1  pulse to replacement controller
- current_access  out  WAY_BITS  way reported to replacement controller; equals array_way
- miss_done  out  1  one-cycle completion pulse
- miss_count  out  32  see Optional Feature
- wb_count  out  32  see Optional Feature

Behaviour:
- **Reset:** all outputs 0 except miss_ready = 1; state IDLE.
  - Reset in any state aborts the miss immediately. Any mem_rsp_valid after reset is ignored.
- **Way encoding:** selected_way is converted to binary using the lowest set bit. All-zero encodes to way 0.
- **States:** IDLE, READ, EVAL, WB_REQ, FILL_REQ, FILL_WAIT, FILL.
- **IDLE:**
  - miss_ready = 1.
  - On miss_valid: latch index, tag and encoded way → READ.
- **READ:** array_rd_en = 1 for exactly one cycle → EVAL.
- **EVAL:**
  - Sample victim_* into registers.
  - If victim_valid & victim_dirty → WB_REQ; else → FILL_REQ.
- **WB_REQ:**
  - mem_req_valid = 1, mem_req_write = 1, addr = {victim_tag, index}, wdata = victim_line.
  - Hold all of these stable until mem_req_ready.
  - On handshake → FILL_REQ. Writes are posted; there is no write response.
- **FILL_REQ:**
  - mem_req_valid = 1, mem_req_write = 0, addr = {miss_tag, index}, wdata = 0.
  - Hold until ready → FILL_WAIT.
- **FILL_WAIT:**
  - On mem_rsp_valid: register mem_rsp_rdata → FILL.
  - mem_rsp_valid is ignored in every other state.
- **FILL:**
  - fill_we, access_valid and miss_done are pulsed for 1 cycle.
  - fill_line/fill_tag are valid in this cycle → IDLE.
- **Outputs outside their states:** mem_req_valid and all pulses are 0 outside their states.
- **Stable outputs:** array_index, array_way and fill_tag remain stable from the cycle after the miss handshake until the next miss is accepted.
- **Back-to-back misses:** a new miss can be accepted in the cycle after FILL.
- **Minimum latency:** clean miss with ready = 1 and response in the first FILL_WAIT cycle gives miss_done 5 cycles after the handshake. A dirty miss adds 1 cycle.
- **Backpressure:** miss_valid while busy is not accepted. The requester must hold it.

Optional Feature:
- Macro: MISS_HANDLER_STATS_EN.
- **Defined:**
  - miss_count increments on each accepted miss.
  - wb_count increments on each writeback handshake.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by reset.
- **Undefined:** both ports are tied to 0 and no counter flops exist.

Test Plan:
- **Clean miss:** reset, then miss index=0x12, tag=0x0ABCD, selected_way=8'b0000_0100; victim_valid=0; ready=1; response 0x1111… in the first FILL_WAIT cycle.
  - array_way=2, no write request.
  - Fill read addr=0x0ABCD12.
  - fill_we, access_valid and miss_done with current_access=2, 5 cycles after the handshake.
- **Dirty victim:** selected_way=8'b1000_0000, victim valid=1, dirty=1, victim_tag=0x00055.
  - First request: write, addr=0x0005512, wdata=victim_line.
  - Then fill read; current_access=7.
- **Backpressure:** mem_req_ready low for 4 cycles in WB_REQ.
  - Request signals stable throughout.
  - Exactly one write handshake; miss_ready stays 0.
- **Malformed one-hot:** selected_way=8'b0011_0000 → way 4. selected_way=0 → way 0.
- **Reset mid-operation:** reset in FILL_WAIT, then a spurious mem_rsp_valid.
  - Returns to IDLE, no fill_we, miss_ready=1.
  - The next miss completes normally.
- **Stats (macro defined):** 3 misses, 1 dirty → miss_count=3, wb_count=1. After reset both are 0.
